// File: rtl/rate_pulse_gen_pkg.sv
// Shared rate encodings and elaboration-time period helpers for the
// enable-pulse generator.
package rate_pkg;

  localparam int CNT_W = 28;

  localparam logic [1:0] RATE_FULL    = 2'b00;
  localparam logic [1:0] RATE_1HZ     = 2'b01;
  localparam logic [1:0] RATE_HALF    = 2'b10;
  localparam logic [1:0] RATE_QUARTER = 2'b11;

  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] sel, input int clk_hz);
    logic [CNT_W-1:0] p;
    case (sel)
      RATE_FULL:    p = CNT_W'(32'sd1);
      RATE_1HZ:     p = CNT_W'(clk_hz);
      RATE_HALF:    p = CNT_W'(32'sd2 * clk_hz);
      RATE_QUARTER: p = CNT_W'(32'sd4 * clk_hz);
      default:      p = CNT_W'(32'sd1);
    endcase
    return p;
  endfunction

  // Counter load value: the counter runs P-1 down to 0, then fires.
  function automatic logic [CNT_W-1:0] reload_of(input logic [1:0] sel, input int clk_hz);
    return period_of(sel, clk_hz) - CNT_W'(32'sd1);
  endfunction

  function automatic bit period_fits(input int clk_hz, input int w);
    longint max_reload;
    max_reload = 64'sd4 * longint'(clk_hz) - 64'sd1;
    return (w >= 63) || ((max_reload >>> w) == 64'sd0);
  endfunction

endpackage

// File: rtl/rate_pulse_gen_if.sv
// Switch inputs and enable/status outputs of the rate pulse generator.
interface rate_pulse_gen_if;
  logic       run;
  logic [1:0] rate_sel;
  logic       pulse;
  logic       active;

  modport master (output run, output rate_sel, input pulse, input active);
  modport slave  (input run, input rate_sel, output pulse, output active);
endinterface

// File: rtl/rate_pulse_gen_sync2.sv
// Two-flop synchroniser for asynchronous board switches, with synchronous
// active-high clear.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clock) begin
    if (clear) begin
      meta <= {W{1'b0}};
      q    <= {W{1'b0}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rate_pulse_gen.sv
// One-clock enable pulse every P clocks, P chosen by rate_sel; run pauses
// the period without losing phase, a rate change restarts it.
module rate_pulse_gen
  import rate_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 28
) (
  input  logic             clock,
  input  logic             clear,
  rate_pulse_gen_if.slave  bus
);

  if (!period_fits(CLK_HZ, CNT_W) || (CNT_W > rate_pkg::CNT_W)) begin : g_bad_cfg
    $error("rate_pulse_gen: period constants do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] RELOAD_FULL    = CNT_W'(reload_of(RATE_FULL, CLK_HZ));
  localparam logic [CNT_W-1:0] RELOAD_1HZ     = CNT_W'(reload_of(RATE_1HZ, CLK_HZ));
  localparam logic [CNT_W-1:0] RELOAD_HALF    = CNT_W'(reload_of(RATE_HALF, CLK_HZ));
  localparam logic [CNT_W-1:0] RELOAD_QUARTER = CNT_W'(reload_of(RATE_QUARTER, CLK_HZ));
  localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             run_s;
  logic [1:0]       sel_s;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload_s;
  logic             pulse_r;
  logic             active_r;

  sync2 #(.W(1)) u_sync_run (
    .clock (clock),
    .clear (clear),
    .d     (bus.run),
    .q     (run_s)
  );

  sync2 #(.W(2)) u_sync_sel (
    .clock (clock),
    .clear (clear),
    .d     (bus.rate_sel),
    .q     (sel_s)
  );

  // Load value for the currently selected rate.
  always_comb begin
    reload_s = RELOAD_FULL;
    case (sel_s)
      RATE_FULL:    reload_s = RELOAD_FULL;
      RATE_1HZ:     reload_s = RELOAD_1HZ;
      RATE_HALF:    reload_s = RELOAD_HALF;
      RATE_QUARTER: reload_s = RELOAD_QUARTER;
      default:      reload_s = RELOAD_FULL;
    endcase
  end

  // Period counter; a rate change outranks everything, including a due pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      sel_q    <= 2'b00;
      cnt      <= CNT_ZERO;
      pulse_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      active_r <= run_s;
      if (sel_s != sel_q) begin
        cnt     <= reload_s;
        pulse_r <= 1'b0;
        sel_q   <= sel_s;
      end else if (!run_s) begin
        pulse_r <= 1'b0;
      end else if (cnt == CNT_ZERO) begin
        pulse_r <= 1'b1;
        cnt     <= reload_s;
      end else begin
        cnt     <= cnt - CNT_ONE;
        pulse_r <= 1'b0;
      end
    end
  end

  assign bus.pulse  = pulse_r;
  assign bus.active = active_r;

endmodule

// File: tb/tb_rate_pulse_gen.sv
// Directed bench for rate_pulse_gen at CLK_HZ=4 (P = 1/4/8/16): expected pulse
// cycles are queued as stimulus is applied and matched as pulses appear.
module tb_rate_pulse_gen;

  logic       clock = 1'b0;
  logic       clear;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_pulse = 0;
  logic [7:0] cnt8    = 8'd0;
  int         exp_q[$];

  always #5 clock = ~clock;

  rate_pulse_gen_if bus ();

  rate_pulse_gen #(.CLK_HZ(4), .CNT_W(28)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One rising edge; outputs sampled 1 time unit later. Any pulse is matched
  // against the next queued expected cycle.
  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    if (bus.pulse !== 1'b0) begin
      n_pulse++;
      cnt8 = cnt8 + 8'd1;
      if (exp_q.size() == 0) check("unexpected_pulse_at_cycle", cyc, 0);
      else                   check("pulse_cycle", cyc, exp_q.pop_front());
    end
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic drain(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // T1: clear for 2 edges with run=1, sel=01; reload at edge 5, pulses every 4.
    clear        = 1'b1;
    bus.run      = 1'b1;
    bus.rate_sel = 2'b01;
    run_until(2);
    check("clear_pulse", bus.pulse, 0);
    check("clear_active", bus.active, 0);
    clear = 1'b0;
    exp_q.push_back(9);
    exp_q.push_back(13);
    exp_q.push_back(17);
    exp_q.push_back(21);
    run_until(4);
    check("active_before_sync", bus.active, 0);
    step();
    check("active_after_sync", bus.active, 1);
    run_until(24);
    drain("t1_missing_pulses");

    // T2: rate 00, run 0 then 1; the 1 Hz pulse due at 25 still fires.
    bus.run      = 1'b0;
    bus.rate_sel = 2'b00;
    exp_q.push_back(25);
    run_until(30);
    bus.run = 1'b1;
    for (int c = 33; c <= 42; c++) exp_q.push_back(c);
    run_until(40);
    bus.run = 1'b0;
    run_until(44);
    check("full_rate_stopped", bus.pulse, 0);
    run_until(46);
    drain("t2_missing_pulses");

    // T3: rate 10, pause 5 clocks with cnt=3 -> pulse 73 slips to 78.
    bus.rate_sel = 2'b10;
    bus.run      = 1'b1;
    exp_q.push_back(57);
    exp_q.push_back(65);
    exp_q.push_back(78);
    exp_q.push_back(86);
    run_until(67);
    bus.run = 1'b0;
    run_until(72);
    bus.run = 1'b1;
    run_until(88);
    drain("t3_missing_pulses");

    // T4: rate 01, switch to 11 landing on the cnt==0 edge (99): no pulse, next at 115.
    bus.rate_sel = 2'b01;
    exp_q.push_back(95);
    exp_q.push_back(115);
    run_until(96);
    bus.rate_sel = 2'b11;
    run_until(121);
    drain("t4_missing_pulses");

    // T5: clear with sel=11, cnt=9; reload at 125, pulse at 141.
    clear = 1'b1;
    step();
    check("midclear_pulse", bus.pulse, 0);
    check("midclear_active", bus.active, 0);
    clear = 1'b0;
    exp_q.push_back(141);
    run_until(124);
    check("midclear_active_sync", bus.active, 0);
    step();
    check("midclear_active_on", bus.active, 1);
    run_until(145);
    drain("t5_missing_pulses");

    // T6: rate 01 for 1024 clocks after reload at 148: 256 pulses, counter wraps to 0.
    bus.rate_sel = 2'b01;
    n_pulse      = 0;
    cnt8         = 8'd0;
    for (int k = 0; k < 256; k++) exp_q.push_back(152 + 4 * k);
    run_until(1172);
    drain("t6_missing_pulses");
    check("t6_pulse_count", n_pulse, 256);
    check("t6_counter_value", {24'd0, cnt8}, 0);
    check("t6_active", bus.active, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
